// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle for the GRF write-port arbiter: W-stage request, secondary
// (mul/div) writeback, GRF write port and hazard-unit pending-write queries.
interface grf_wb_arbiter_if;
  logic        p_valid;
  logic [4:0]  p_a3;
  logic [31:0] p_wd;
  logic [31:0] p_pc;
  logic        p_stall;

  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_a3;
  logic [31:0] s_wd;
  logic [31:0] s_pc;

  logic        reg_write;
  logic [4:0]  a3;
  logic [31:0] wd;
  logic [31:0] pc;

  logic [4:0]  q_a1;
  logic [4:0]  q_a2;
  logic        q_hit1;
  logic        q_hit2;

  modport master (
    output p_valid, p_a3, p_wd, p_pc,
    input  p_stall,
    output s_valid, s_a3, s_wd, s_pc,
    input  s_ready,
    input  reg_write, a3, wd, pc,
    output q_a1, q_a2,
    input  q_hit1, q_hit2
  );

  modport slave (
    input  p_valid, p_a3, p_wd, p_pc,
    output p_stall,
    input  s_valid, s_a3, s_wd, s_pc,
    output s_ready,
    output reg_write, a3, wd, pc,
    input  q_a1, q_a2,
    output q_hit1, q_hit2
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Shares the GRF write port between the W stage and a buffered mul/div writeback path.
// Define GRF_WB_STARVE_GUARD_EN to compile in the starvation counter that stalls W.
module grf_wb_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic            clk,
  input logic            reset,
  grf_wb_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_cfg
    $error("grf_wb_arbiter: DEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
  end

  logic [4:0]    r_a3 [DEPTH];
  logic [31:0]   r_wd [DEPTH];
  logic [31:0]   r_pc [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_p_eff;
  logic w_stall;
  logic w_p_grant;
  logic w_f_grant;
  logic w_s_ready;
  logic w_push;
  logic w_hit1;
  logic w_hit2;

  assign w_p_eff   = bus.p_valid && (bus.p_a3 != 5'd0);
  assign w_s_ready = (r_count < CW'(DEPTH));
  // Grants are suppressed in the reset cycle so nothing reaches the GRF then.
  assign w_p_grant = !reset && w_p_eff && !w_stall;
  assign w_f_grant = !reset && (r_count != '0) && (!w_p_eff || w_stall);
  // Writes to $0 are accepted from the producer but never occupy an entry.
  assign w_push    = !reset && bus.s_valid && w_s_ready && (bus.s_a3 != 5'd0);

`ifdef GRF_WB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(MAX_WAIT + 1);
  logic [SW-1:0] r_starve;

  always_ff @(posedge clk) begin
    if (reset || r_count == '0 || w_f_grant) begin
      r_starve <= '0;
    end else if (r_starve != SW'(MAX_WAIT)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign w_stall = (r_starve == SW'(MAX_WAIT));
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_f_grant) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_f_grant})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_a3[r_wr_ptr] <= bus.s_a3;
      r_wd[r_wr_ptr] <= bus.s_wd;
      r_pc[r_wr_ptr] <= bus.s_pc;
    end
  end

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_hit1 = w_hit1 | (r_vld[i] & (r_a3[i] == bus.q_a1));
      w_hit2 = w_hit2 | (r_vld[i] & (r_a3[i] == bus.q_a2));
    end
  end

  always_comb begin
    bus.reg_write = 1'b0;
    bus.a3        = '0;
    bus.wd        = '0;
    bus.pc        = '0;
    if (w_p_grant) begin
      bus.reg_write = 1'b1;
      bus.a3        = bus.p_a3;
      bus.wd        = bus.p_wd;
      bus.pc        = bus.p_pc;
    end else if (w_f_grant) begin
      bus.reg_write = 1'b1;
      bus.a3        = r_a3[r_rd_ptr];
      bus.wd        = r_wd[r_rd_ptr];
      bus.pc        = r_pc[r_rd_ptr];
    end
  end

  assign bus.p_stall = w_stall;
  assign bus.s_ready = w_s_ready;
  assign bus.q_hit1  = w_hit1 && (bus.q_a1 != 5'd0);
  assign bus.q_hit2  = w_hit2 && (bus.q_a2 != 5'd0);

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_grf_wb_arbiter;

  localparam int unsigned DEPTH    = 2;
  localparam int unsigned MAX_WAIT = 4;
`ifdef GRF_WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wb_arbiter_if bus ();

  grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  int unsigned wait_cyc;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the pending queue and the ungranted streak.
  logic        e_stall, e_peff, e_pg, e_fg, e_rdy, e_h1, e_h2, e_we;
  logic [4:0]  e_a3;
  logic [31:0] e_wd, e_pc;
  ent_t        e_new;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_reg_write", {31'd0, bus.reg_write}, 32'd0);
      mq.delete();
      wait_cyc = 0;
    end else begin
      e_stall = GUARD && (wait_cyc == MAX_WAIT);
      e_peff  = bus.p_valid && (bus.p_a3 != 0);
      e_pg    = e_peff && !e_stall;
      e_fg    = (mq.size() != 0) && !e_pg;
      e_rdy   = mq.size() < DEPTH;
      e_h1 = 1'b0;
      e_h2 = 1'b0;
      foreach (mq[i]) begin
        if (mq[i].a3 == bus.q_a1) e_h1 = 1'b1;
        if (mq[i].a3 == bus.q_a2) e_h2 = 1'b1;
      end
      e_we = e_pg || e_fg;
      e_a3 = e_pg ? bus.p_a3 : (e_fg ? mq[0].a3 : 5'd0);
      e_wd = e_pg ? bus.p_wd : (e_fg ? mq[0].wd : 32'd0);
      e_pc = e_pg ? bus.p_pc : (e_fg ? mq[0].pc : 32'd0);
      chk("reg_write", {31'd0, bus.reg_write}, {31'd0, e_we});
      chk("a3", {27'd0, bus.a3}, {27'd0, e_a3});
      chk("wd", bus.wd, e_wd);
      chk("pc", bus.pc, e_pc);
      chk("p_stall", {31'd0, bus.p_stall}, {31'd0, e_stall});
      chk("s_ready", {31'd0, bus.s_ready}, {31'd0, e_rdy});
      chk("q_hit1", {31'd0, bus.q_hit1}, {31'd0, e_h1});
      chk("q_hit2", {31'd0, bus.q_hit2}, {31'd0, e_h2});
      if (mq.size() == 0 || e_fg) wait_cyc = 0;
      else if (wait_cyc < MAX_WAIT) wait_cyc++;
      if (e_fg) void'(mq.pop_front());
      if (bus.s_valid && e_rdy && bus.s_a3 != 0) begin
        e_new.a3 = bus.s_a3;
        e_new.wd = bus.s_wd;
        e_new.pc = bus.s_pc;
        mq.push_back(e_new);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_p(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.p_valid = v;
    bus.p_a3    = a;
    bus.p_wd    = d;
    bus.p_pc    = d ^ 32'h0040_0000;
  endtask

  task automatic set_s(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.s_valid = v;
    bus.s_a3    = a;
    bus.s_wd    = d;
    bus.s_pc    = d ^ 32'h0030_0000;
  endtask

  initial begin
    int unsigned pv_pct;
    reset = 1'b1;
    set_p(0, 0, 0);
    set_s(0, 0, 0);
    bus.q_a1 = 5'd0;
    bus.q_a2 = 5'd0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    settle();
    chk("lit_rst_reg_write", {31'd0, bus.reg_write}, 32'd0);
    chk("lit_rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
    chk("lit_rst_p_stall", {31'd0, bus.p_stall}, 32'd0);
    chk("lit_rst_a3", {27'd0, bus.a3}, 32'd0);

    // Primary write is combinational
    next_cycle();
    set_p(1, 5, 32'h1234);
    settle();
    chk("lit_p_we", {31'd0, bus.reg_write}, 32'd1);
    chk("lit_p_a3", {27'd0, bus.a3}, 32'd5);
    chk("lit_p_wd", bus.wd, 32'h1234);
    chk("lit_p_stall0", {31'd0, bus.p_stall}, 32'd0);

    // Secondary with idle W: one cycle latency
    next_cycle();
    set_p(0, 0, 0);
    set_s(1, 8, 32'hABCD);
    settle();
    chk("lit_s_idle_we", {31'd0, bus.reg_write}, 32'd0);
    next_cycle();
    set_s(0, 0, 0);
    settle();
    chk("lit_s_we", {31'd0, bus.reg_write}, 32'd1);
    chk("lit_s_a3", {27'd0, bus.a3}, 32'd8);
    chk("lit_s_wd", bus.wd, 32'hABCD);
    next_cycle();
    settle();
    chk("lit_s_empty_we", {31'd0, bus.reg_write}, 32'd0);

    // Fill FIFO under busy W; third offer must be held
    next_cycle();
    set_p(1, 3, 32'h33);
    set_s(1, 8, 32'h88);
    settle();
    next_cycle();
    set_s(1, 9, 32'h99);
    settle();
    next_cycle();
    set_s(1, 10, 32'hAA);
    bus.q_a1 = 5'd8;
    settle();
    chk("lit_full_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("lit_full_hit1", {31'd0, bus.q_hit1}, 32'd1);
    chk("lit_full_a3", {27'd0, bus.a3}, 32'd3);
    next_cycle();
    set_p(0, 0, 0);
    settle();
    chk("lit_drain0_a3", {27'd0, bus.a3}, 32'd8);
    chk("lit_drain0_ready", {31'd0, bus.s_ready}, 32'd0);
    next_cycle();
    settle();
    chk("lit_drain1_a3", {27'd0, bus.a3}, 32'd9);
    chk("lit_drain1_ready", {31'd0, bus.s_ready}, 32'd1);
    next_cycle();
    set_s(0, 0, 0);
    settle();
    chk("lit_drain2_a3", {27'd0, bus.a3}, 32'd10);
    chk("lit_drain2_wd", bus.wd, 32'hAA);
    chk("lit_drain2_hit1", {31'd0, bus.q_hit1}, 32'd0);
    next_cycle();
    settle();
    chk("lit_drain3_we", {31'd0, bus.reg_write}, 32'd0);

    // Starvation under continuous W traffic
    next_cycle();
    set_p(1, 3, 32'h33);
    set_s(1, 12, 32'hC0);
    settle();
    next_cycle();
    set_s(0, 0, 0);
    settle();
    for (int k = 0; k < 4; k++) begin
      chk("lit_starve_wait_stall", {31'd0, bus.p_stall}, 32'd0);
      chk("lit_starve_wait_a3", {27'd0, bus.a3}, 32'd3);
      next_cycle();
      settle();
    end
    chk("lit_starve_stall", {31'd0, bus.p_stall}, GUARD ? 32'd1 : 32'd0);
    chk("lit_starve_a3", {27'd0, bus.a3}, GUARD ? 32'd12 : 32'd3);
    next_cycle();
    if (!GUARD) set_p(0, 0, 0);
    settle();
    chk("lit_starve_after_stall", {31'd0, bus.p_stall}, 32'd0);
    chk("lit_starve_after_a3", {27'd0, bus.a3}, GUARD ? 32'd3 : 32'd12);
    next_cycle();
    set_p(0, 0, 0);
    settle();

    // Primary to $0 leaves the port to the FIFO
    next_cycle();
    set_p(1, 3, 32'h33);
    set_s(1, 14, 32'hE0);
    settle();
    next_cycle();
    set_s(0, 0, 0);
    set_p(1, 0, 32'hDEAD);
    settle();
    chk("lit_zero_we", {31'd0, bus.reg_write}, 32'd1);
    chk("lit_zero_a3", {27'd0, bus.a3}, 32'd14);
    chk("lit_zero_wd", bus.wd, 32'hE0);
    next_cycle();
    settle();
    chk("lit_zero_idle_we", {31'd0, bus.reg_write}, 32'd0);

    // $0 secondary is discarded; reset flushes buffered entries
    next_cycle();
    set_p(1, 3, 32'h33);
    set_s(1, 0, 32'h0);
    settle();
    next_cycle();
    set_s(1, 13, 32'hD0);
    settle();
    next_cycle();
    set_s(1, 15, 32'hF0);
    settle();
    chk("lit_s0_ready", {31'd0, bus.s_ready}, 32'd1);
    next_cycle();
    set_s(0, 0, 0);
    bus.q_a1 = 5'd13;
    settle();
    chk("lit_s0_full", {31'd0, bus.s_ready}, 32'd0);
    chk("lit_s0_hit1", {31'd0, bus.q_hit1}, 32'd1);
    next_cycle();
    reset = 1'b1;
    settle();
    chk("lit_midrst_we", {31'd0, bus.reg_write}, 32'd0);
    next_cycle();
    reset = 1'b0;
    set_p(0, 0, 0);
    settle();
    chk("lit_postrst_ready", {31'd0, bus.s_ready}, 32'd1);
    chk("lit_postrst_we", {31'd0, bus.reg_write}, 32'd0);
    chk("lit_postrst_hit1", {31'd0, bus.q_hit1}, 32'd0);

    // Randomized traffic against the model
    pv_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      if (c % 64 == 0) pv_pct = $urandom_range(0, 95);
      reset = ($urandom_range(0, 299) == 0);
      set_p($urandom_range(0, 99) < pv_pct,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom());
      set_s(!reset && ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
            $urandom());
      bus.q_a1 = 5'($urandom_range(0, 7));
      bus.q_a2 = 5'($urandom_range(0, 7));
      settle();
    end

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
